// File: rtl/reg_trigger_delay_pkg.sv
// reg_trigger_delay_pkg: register addresses and byte-lane helper for reg_trigger_delay
package reg_trigger_delay_pkg;
    localparam logic [5:0] REG_TRIGDLY_DELAY = 6'd50;
    localparam logic [5:0] REG_TRIGDLY_WIDTH = 6'd51;
    localparam logic [5:0] REG_TRIGDLY_CTRL  = 6'd52;
    localparam logic [5:0] REG_TRIGDLY_COUNT = 6'd53;

    function automatic logic [7:0] byte_lane(input logic [31:0] v, input logic [1:0] idx);
        return v[{idx, 3'b000} +: 8];
    endfunction
endpackage

// File: rtl/trig_edge_sync.sv
// trig_edge_sync: 2-flop synchronizer with a one-cycle rising-edge pulse taken from synchronized flops only
module trig_edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);
    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q && !s3_q;
endmodule

// File: rtl/reg_trigger_delay.sv
// reg_trigger_delay: register-mapped trigger delay and fixed-width pulse shaper
module reg_trigger_delay
    import reg_trigger_delay_pkg::*;
#(
    parameter logic [5:0] pADDR_DELAY = REG_TRIGDLY_DELAY,
    parameter logic [5:0] pADDR_WIDTH = REG_TRIGDLY_WIDTH,
    parameter logic [5:0] pADDR_CTRL  = REG_TRIGDLY_CTRL,
    parameter logic [5:0] pADDR_COUNT = REG_TRIGDLY_COUNT,
    parameter int         CNT_W       = 16
) (
    input  logic        clk_usb,
    input  logic        reset_i,
    input  logic [5:0]  reg_address,
    input  logic [15:0] reg_bytecnt,
    input  logic [7:0]  reg_datai,
    output logic [7:0]  reg_datao,
    input  logic        reg_read,
    input  logic        reg_write,
    input  logic        reg_addrvalid,
    input  logic [5:0]  reg_hypaddress,
    output logic [15:0] reg_hyplen,
    input  logic        trig_i,
    output logic        trig_o,
    output logic        busy_o
);
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DELAY, S_PULSE} state_e;

    state_e           state_q;
    logic [31:0]      delay_q, dcnt_q, rd_val;
    logic [15:0]      width_q, wcnt_q;
    logic [CNT_W-1:0] count_q;
    logic [7:0]       ctrl_rd;
    logic             en_q, rearm_q, missed_q, trig_q;
    logic             rise, wr, wr_ctrl, en_d, arm, clr, unused_rd;

    function automatic logic [15:0] len_of(input logic [5:0] a);
        return a == pADDR_DELAY ? 16'd4 :
               a == pADDR_WIDTH ? 16'd2 :
               a == pADDR_CTRL  ? 16'd1 :
               a == pADDR_COUNT ? 16'd2 : 16'd0;
    endfunction

    trig_edge_sync u_sync (
        .clk_i  (clk_usb),
        .rst_i  (reset_i),
        .d_i    (trig_i),
        .rise_o (rise)
    );

    assign unused_rd = reg_read;
    assign wr        = reg_write && reg_addrvalid;
    assign wr_ctrl   = wr && reg_address == pADDR_CTRL && reg_bytecnt == 16'd0;
    assign en_d      = wr_ctrl ? reg_datai[0] : en_q;
    assign arm       = wr_ctrl && reg_datai[2];
    assign clr       = wr_ctrl && reg_datai[3];
    assign busy_o    = state_q == S_DELAY || state_q == S_PULSE;
    assign trig_o    = trig_q;

    always_ff @(posedge clk_usb) begin
        if (reset_i) begin
            delay_q <= '0;
            width_q <= '0;
            en_q    <= 1'b0;
            rearm_q <= 1'b0;
        end else begin
            if (wr && reg_address == pADDR_DELAY && reg_bytecnt < 16'd4)
                delay_q[{reg_bytecnt[1:0], 3'b000} +: 8] <= reg_datai;
            if (wr && reg_address == pADDR_WIDTH && reg_bytecnt < 16'd2)
                width_q[{reg_bytecnt[0], 3'b000} +: 8] <= reg_datai;
            if (wr_ctrl) begin
                en_q    <= reg_datai[0];
                rearm_q <= reg_datai[1];
            end
        end
    end

    // Enable is taken from the in-flight write so a disable beats a same-cycle edge
    always_ff @(posedge clk_usb) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            dcnt_q   <= '0;
            wcnt_q   <= '0;
            count_q  <= '0;
            missed_q <= 1'b0;
            trig_q   <= 1'b0;
        end else begin
            if (clr) begin
                count_q  <= '0;
                missed_q <= 1'b0;
            end else begin
                if (rise && busy_o)
                    missed_q <= 1'b1;
                if (state_q == S_PULSE && wcnt_q == 16'd1 && count_q != '1)
                    count_q <= count_q + CNT_W'(1);
            end
            if (!en_d) begin
                state_q <= S_IDLE;
                trig_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE:  if (arm) state_q <= S_ARMED;
                    S_ARMED: if (rise) begin
                        state_q <= S_DELAY;
                        dcnt_q  <= delay_q;
                        wcnt_q  <= width_q == 16'd0 ? 16'd1 : width_q;
                    end
                    S_DELAY: if (dcnt_q == 32'd0) begin
                        state_q <= S_PULSE;
                        trig_q  <= 1'b1;
                    end else dcnt_q <= dcnt_q - 32'd1;
                    S_PULSE: if (wcnt_q == 16'd1) begin
                        state_q <= rearm_q ? S_ARMED : S_IDLE;
                        trig_q  <= 1'b0;
                    end else wcnt_q <= wcnt_q - 16'd1;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign ctrl_rd    = {1'b0, missed_q, busy_o, state_q == S_ARMED, 2'b00, rearm_q, en_q};
    assign rd_val     = reg_address == pADDR_DELAY ? delay_q :
                        reg_address == pADDR_WIDTH ? {16'h0000, width_q} :
                        reg_address == pADDR_CTRL  ? {24'h000000, ctrl_rd} : 32'(count_q);
    assign reg_datao  = (reg_addrvalid && reg_bytecnt < len_of(reg_address)) ?
                        byte_lane(rd_val, reg_bytecnt[1:0]) : 8'h00;
    assign reg_hyplen = len_of(reg_hypaddress);
endmodule

// File: tb/tb_reg_trigger_delay.sv
// tb_reg_trigger_delay: randomized self-checking bench with a timing-rule reference model
module tb_reg_trigger_delay;
    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [5:0] A_DLY = 6'd50, A_WID = 6'd51, A_CTL = 6'd52, A_CNT = 6'd53;

    logic        clk_usb = 1'b0, reset_i = 1'b1;
    logic [5:0]  reg_address = '0, reg_hypaddress = '0;
    logic [15:0] reg_bytecnt = '0, reg_hyplen;
    logic [7:0]  reg_datai = '0, reg_datao;
    logic        reg_read = 1'b0, reg_write = 1'b0, reg_addrvalid = 1'b0;
    logic        trig_i = 1'b0, trig_o, busy_o;

    int vectors = 0, miscompares = 0, model_count = 0;
    logic model_missed = 1'b0;

    always #5 clk_usb = ~clk_usb;

    reg_trigger_delay #(.CNT_W(CNT_W)) dut (
        .clk_usb        (clk_usb),
        .reset_i        (reset_i),
        .reg_address    (reg_address),
        .reg_bytecnt    (reg_bytecnt),
        .reg_datai      (reg_datai),
        .reg_datao      (reg_datao),
        .reg_read       (reg_read),
        .reg_write      (reg_write),
        .reg_addrvalid  (reg_addrvalid),
        .reg_hypaddress (reg_hypaddress),
        .reg_hyplen     (reg_hyplen),
        .trig_i         (trig_i),
        .trig_o         (trig_o),
        .busy_o         (busy_o)
    );

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk_usb);
            #1;
        end
    endtask

    task automatic wr(input logic [5:0] a, input int b, input logic [7:0] d);
        reg_address = a;
        reg_bytecnt = 16'(b);
        reg_datai = d;
        reg_write = 1'b1;
        reg_addrvalid = 1'b1;
        cycles(1);
        reg_write = 1'b0;
        reg_addrvalid = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, input int first, input int n, output logic [31:0] v);
        @(negedge clk_usb);
        v = '0;
        reg_address = a;
        reg_addrvalid = 1'b1;
        reg_read = 1'b1;
        for (int i = 0; i < n; i++) begin
            reg_bytecnt = 16'(first + i);
            #1;
            v[i*8 +: 8] = reg_datao;
        end
        reg_addrvalid = 1'b0;
        reg_read = 1'b0;
    endtask

    task automatic set_dw(input int d, input int w);
        for (int i = 0; i < 4; i++) wr(A_DLY, i, 8'(d >> (8 * i)));
        for (int i = 0; i < 2; i++) wr(A_WID, i, 8'(w >> (8 * i)));
    endtask

    // Edge 0 is the first edge that samples trig_i high; k counts edges after it
    task automatic measure(input int lim, input int miss_k, output int fh, output int lh,
                           output int nh, output int fb, output int lb);
        fh = -1; lh = -1; nh = 0; fb = -1; lb = -1;
        trig_i = 1'b1;
        cycles(1);
        trig_i = 1'b0;
        for (int k = 1; k <= lim; k++) begin
            cycles(1);
            if (trig_o) begin
                if (fh < 0) fh = k;
                lh = k;
                nh++;
            end
            if (busy_o) begin
                if (fb < 0) fb = k;
                lb = k;
            end
            trig_i = (k == miss_k);
        end
    endtask

    task automatic test_reset;
        logic [31:0] v;
        logic [5:0] ad [4] = '{A_DLY, A_WID, A_CTL, A_CNT};
        int ln [4] = '{4, 2, 1, 2};
        reset_i = 1'b1;
        cycles(3);
        @(negedge clk_usb);
        if ({trig_o, busy_o, reg_datao, reg_hyplen} !== 26'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got trig=%b busy=%b datao=%h hyplen=%h exp all 0",
                     trig_o, busy_o, reg_datao, reg_hyplen);
        end
        vectors++;
        reset_i = 1'b0;
        cycles(1);
        for (int i = 0; i < 4; i++) begin
            rd(ad[i], 0, ln[i], v);
            if (v !== 32'd0) begin
                miscompares++;
                $display("FAIL reset_reg addr=%0d got %h exp 0", ad[i], v);
            end
            vectors++;
        end
    endtask

    task automatic test_bus;
        logic [31:0] v;
        logic [5:0] ha [5] = '{A_DLY, A_WID, A_CTL, A_CNT, 6'd40};
        int hl [5] = '{4, 2, 1, 2, 0};
        wr(A_DLY, 0, 8'h78); wr(A_DLY, 1, 8'h56); wr(A_DLY, 2, 8'h34); wr(A_DLY, 3, 8'h12);
        wr(A_DLY, 4, 8'hAA);
        rd(A_DLY, 0, 4, v);
        if (v !== 32'h12345678) begin
            miscompares++;
            $display("FAIL bus_delay got %h exp 12345678", v);
        end
        vectors++;
        rd(A_DLY, 4, 1, v);
        if (v !== 32'd0) begin
            miscompares++;
            $display("FAIL bus_delay_byte4 got %h exp 0", v);
        end
        vectors++;
        wr(A_WID, 0, 8'hEF); wr(A_WID, 1, 8'hBE); wr(A_WID, 2, 8'h55);
        rd(A_WID, 0, 2, v);
        if (v !== 32'h0000BEEF) begin
            miscompares++;
            $display("FAIL bus_width got %h exp beef", v);
        end
        vectors++;
        wr(A_CNT, 0, 8'h33);
        rd(A_CNT, 0, 2, v);
        if (v !== 32'd0) begin
            miscompares++;
            $display("FAIL bus_count_ro got %h exp 0", v);
        end
        vectors++;
        rd(6'd40, 0, 1, v);
        if (v !== 32'd0) begin
            miscompares++;
            $display("FAIL bus_unowned got %h exp 0", v);
        end
        vectors++;
        @(negedge clk_usb);
        reg_address = A_DLY;
        reg_bytecnt = 16'd0;
        #1;
        if (reg_datao !== 8'h00) begin
            miscompares++;
            $display("FAIL bus_no_addrvalid got %h exp 0", reg_datao);
        end
        vectors++;
        for (int i = 0; i < 5; i++) begin
            reg_hypaddress = ha[i];
            #1;
            if (reg_hyplen !== 16'(hl[i])) begin
                miscompares++;
                $display("FAIL bus_hyplen addr=%0d got %0d exp %0d", ha[i], reg_hyplen, hl[i]);
            end
            vectors++;
        end
        reg_hypaddress = '0;
    endtask

    task automatic test_pulse(input string nm, input int d, input int w, input int gap);
        int fh, lh, nh, fb, lb, wm;
        logic [31:0] v;
        wm = (w == 0) ? 1 : w;
        set_dw(d, w);
        wr(A_CTL, 0, 8'h05);
        cycles(gap);
        measure(3 + d + wm + 3, -1, fh, lh, nh, fb, lb);
        model_count = (model_count < CNT_MAX) ? model_count + 1 : CNT_MAX;
        if ({fh, lh, nh, fb, lb} !== {3 + d, 2 + d + wm, wm, 2, 2 + d + wm}) begin
            miscompares++;
            $display("FAIL %s_window d=%0d w=%0d got rise=%0d last=%0d n=%0d busy=%0d..%0d exp rise=%0d last=%0d n=%0d busy=2..%0d",
                     nm, d, w, fh, lh, nh, fb, lb, 3 + d, 2 + d + wm, wm, 2 + d + wm);
        end
        vectors++;
        rd(A_CTL, 0, 1, v);
        if (v !== {24'd0, 1'b0, model_missed, 6'h01}) begin
            miscompares++;
            $display("FAIL %s_ctrl got %h exp %h", nm, v, {1'b0, model_missed, 6'h01});
        end
        vectors++;
        rd(A_CNT, 0, 2, v);
        if (v !== 32'(model_count)) begin
            miscompares++;
            $display("FAIL %s_count got %0d exp %0d", nm, v, model_count);
        end
        vectors++;
    endtask

    task automatic test_basic;
        test_pulse("basic", 5, 3, 0);
    endtask

    task automatic test_zero;
        test_pulse("zero", 0, 0, 0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++)
            test_pulse("random", $urandom_range(12, 0), $urandom_range(8, 0), $urandom_range(4, 1));
    endtask

    task automatic test_missed_rearm;
        int fh, lh, nh, fb, lb;
        logic [31:0] v;
        wr(A_CTL, 0, 8'h08);
        model_count = 0;
        model_missed = 1'b0;
        set_dw(6, 2);
        wr(A_CTL, 0, 8'h07);
        for (int p = 0; p < 2; p++) begin
            measure(3 + 6 + 2 + 3, p == 0 ? 4 : -1, fh, lh, nh, fb, lb);
            model_count++;
            if (p == 0) model_missed = 1'b1;
            if ({fh, lh, nh, fb, lb} !== {9, 10, 2, 2, 10}) begin
                miscompares++;
                $display("FAIL missed_window pulse=%0d got rise=%0d last=%0d n=%0d busy=%0d..%0d exp 9 10 2 2..10",
                         p, fh, lh, nh, fb, lb);
            end
            vectors++;
            rd(A_CTL, 0, 1, v);
            if (v !== {24'd0, 1'b0, model_missed, 6'h13}) begin
                miscompares++;
                $display("FAIL missed_ctrl pulse=%0d got %h exp %h", p, v, {1'b0, model_missed, 6'h13});
            end
            vectors++;
        end
        rd(A_CNT, 0, 2, v);
        if (v !== 32'(model_count)) begin
            miscompares++;
            $display("FAIL missed_count got %0d exp %0d", v, model_count);
        end
        vectors++;
    endtask

    task automatic test_collision;
        int nh;
        logic [31:0] v;
        wr(A_CTL, 0, 8'h00);
        wr(A_CTL, 0, 8'h01);
        trig_i = 1'b1;
        cycles(1);
        trig_i = 1'b0;
        cycles(1);
        wr(A_CTL, 0, 8'h05);
        nh = 0;
        for (int k = 0; k < 15; k++) begin
            cycles(1);
            if (trig_o) nh++;
        end
        if (nh !== 0) begin
            miscompares++;
            $display("FAIL collision_pulse got %0d high cycles exp 0", nh);
        end
        vectors++;
        rd(A_CTL, 0, 1, v);
        if (v !== {24'd0, 1'b0, model_missed, 6'h11}) begin
            miscompares++;
            $display("FAIL collision_ctrl got %h exp %h", v, {1'b0, model_missed, 6'h11});
        end
        vectors++;
    endtask

    task automatic test_disable;
        logic [31:0] v;
        set_dw(2, 6);
        trig_i = 1'b1;
        cycles(1);
        trig_i = 1'b0;
        cycles(7);
        if (trig_o !== 1'b1) begin
            miscompares++;
            $display("FAIL disable_prepulse got trig=%b exp 1", trig_o);
        end
        vectors++;
        wr(A_CTL, 0, 8'h00);
        if ({trig_o, busy_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL disable_outputs got trig=%b busy=%b exp 0 0", trig_o, busy_o);
        end
        vectors++;
        rd(A_CTL, 0, 1, v);
        if (v !== {24'd0, 1'b0, model_missed, 6'h00}) begin
            miscompares++;
            $display("FAIL disable_ctrl got %h exp %h", v, {1'b0, model_missed, 6'h00});
        end
        vectors++;
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        set_dw(20, 1);
        wr(A_CTL, 0, 8'h05);
        trig_i = 1'b1;
        cycles(1);
        trig_i = 1'b0;
        cycles(4);
        if (busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL resetmid_busy got %b exp 1", busy_o);
        end
        vectors++;
        reset_i = 1'b1;
        cycles(1);
        reset_i = 1'b0;
        model_count = 0;
        model_missed = 1'b0;
        if ({trig_o, busy_o, reg_datao} !== 10'd0) begin
            miscompares++;
            $display("FAIL resetmid_outputs got trig=%b busy=%b datao=%h exp 0", trig_o, busy_o, reg_datao);
        end
        vectors++;
        rd(A_CTL, 0, 1, v);
        if (v !== 32'd0) begin
            miscompares++;
            $display("FAIL resetmid_ctrl got %h exp 0", v);
        end
        vectors++;
        rd(A_DLY, 0, 4, v);
        if (v !== 32'd0) begin
            miscompares++;
            $display("FAIL resetmid_delay got %h exp 0", v);
        end
        vectors++;
    endtask

    task automatic test_saturate_clear;
        logic [31:0] v;
        set_dw(0, 1);
        wr(A_CTL, 0, 8'h0F);
        model_count = 0;
        model_missed = 1'b0;
        repeat (CNT_MAX + 5) begin
            trig_i = 1'b1;
            cycles(1);
            trig_i = 1'b0;
            cycles(3);
            model_count = (model_count < CNT_MAX) ? model_count + 1 : CNT_MAX;
        end
        cycles(6);
        rd(A_CNT, 0, 2, v);
        if (v !== 32'(model_count)) begin
            miscompares++;
            $display("FAIL sat_count got %0d exp %0d", v, model_count);
        end
        vectors++;
        trig_i = 1'b1; cycles(1);
        trig_i = 1'b0; cycles(1);
        trig_i = 1'b1; cycles(1);
        trig_i = 1'b0; cycles(8);
        model_missed = 1'b1;
        rd(A_CTL, 0, 1, v);
        if (v !== 32'h53) begin
            miscompares++;
            $display("FAIL sat_missed_ctrl got %h exp 53", v);
        end
        vectors++;
        rd(A_CNT, 0, 2, v);
        if (v !== 32'(model_count)) begin
            miscompares++;
            $display("FAIL sat_hold got %0d exp %0d", v, model_count);
        end
        vectors++;
        trig_i = 1'b1;
        cycles(1);
        trig_i = 1'b0;
        cycles(3);
        if (trig_o !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_prepulse got trig=%b exp 1", trig_o);
        end
        vectors++;
        wr(A_CTL, 0, 8'h0B);
        model_count = 0;
        model_missed = 1'b0;
        rd(A_CNT, 0, 2, v);
        if (v !== 32'd0) begin
            miscompares++;
            $display("FAIL clear_count got %0d exp 0", v);
        end
        vectors++;
        rd(A_CTL, 0, 1, v);
        if (v !== 32'h13) begin
            miscompares++;
            $display("FAIL clear_ctrl got %h exp 13", v);
        end
        vectors++;
    endtask

    initial begin
        test_reset();
        test_bus();
        test_basic();
        test_zero();
        test_random();
        test_missed_rearm();
        test_collision();
        test_disable();
        test_reset_mid();
        test_saturate_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
